// File: rtl/bus_counter_gen_if.sv
// bus: point-to-point data link between a source and a buffer stage.
// DW is owned by the interface instance; endpoints derive it from here.
interface bus #(
  parameter int DW = 8
) ();
  logic [DW-1:0] dat;

  modport o (output dat);
  modport i (input dat);
endinterface

// File: rtl/bus_counter_gen.sv
// bus_counter_gen: burst counter source driving bus.dat.
// Wrap, saturate and ping-pong counting with run-time length/abort.
module bus_counter_gen #(
  parameter int STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] len,
  input  logic [15:0] init,
  input  logic [1:0]  mode,
  output logic        busy,
  output logic        done,
  bus.o               o
);

  localparam int DW = $bits(o.dat);
  localparam logic [DW-1:0] STP = DW'(STEP);
  localparam logic [DW-1:0] MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [DW-1:0] dat;
  logic [15:0]   rem;
  logic [1:0]    md;
  logic          dn;

  logic [DW:0]   sum;
  logic [DW-1:0] nxt;
  logic          nxt_dn;

  assign o.dat = dat;
  assign sum   = {1'b0, dat} + {1'b0, STP};

  // next counter value and ping-pong direction for the latched mode
  always_comb begin
    nxt    = dat;
    nxt_dn = dn;
    unique case (md)
      2'b00: nxt = sum[DW-1:0];
      2'b01: nxt = dat - STP;
      2'b10: nxt = sum[DW] ? MAX : sum[DW-1:0];
      2'b11: begin
        if (!dn) begin
          if (sum >= {1'b0, MAX}) begin
            nxt    = MAX;
            nxt_dn = 1'b1;
          end else begin
            nxt = sum[DW-1:0];
          end
        end else begin
          if (dat <= STP) begin
            nxt    = '0;
            nxt_dn = 1'b0;
          end else begin
            nxt = dat - STP;
          end
        end
      end
      default: nxt = dat;
    endcase
  end

  // burst sequencer with registered busy/done
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dat   <= '0;
      rem   <= '0;
      md    <= 2'b00;
      dn    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start && !stop) begin
            if (len != 16'd0) begin
              state <= RUN;
              dat   <= init[DW-1:0];
              rem   <= len - 16'd1;
              md    <= mode;
              dn    <= 1'b0;
              busy  <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end else if (rem == 16'd0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            dat <= nxt;
            dn  <= nxt_dn;
            rem <= rem - 16'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_counter_gen.sv
// tb_bus_counter_gen: scoreboard bench, DW=4 with STEP=1 and STEP=2.
// Stimulus queues expected bus values; monitors pop on busy.
module tb_bus_counter_gen;

  logic        clk;
  logic        rst;
  logic        start;
  logic        start2;
  logic        stop;
  logic [15:0] len;
  logic [15:0] init;
  logic [1:0]  mode;
  logic        busy1, done1;
  logic        busy2, done2;

  bus #(.DW(4)) b1 ();
  bus #(.DW(4)) b2 ();

  bus_counter_gen #(.STEP(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .len(len), .init(init), .mode(mode),
    .busy(busy1), .done(done1), .o(b1)
  );

  bus_counter_gen #(.STEP(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .stop(stop),
    .len(len), .init(init), .mode(mode),
    .busy(busy2), .done(done2), .o(b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int q1[$];
  int q2[$];
  int got_done1 = 0;
  int got_done2 = 0;
  int exp_done1 = 0;
  int exp_done2 = 0;
  logic prev_done1 = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  // monitor for the STEP=1 instance
  always @(negedge clk) begin
    int e;
    if (busy1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL dat1_extra got %0d want none", b1.dat);
      end else begin
        e = q1.pop_front();
        if (int'(b1.dat) != e) begin
          errors++;
          $display("FAIL dat1 got %0d want %0d", b1.dat, e);
        end
      end
    end
    if (busy1 || done1) begin
      checks++;
      if (busy1 && done1) begin
        errors++;
        $display("FAIL busy_done1 got 1 want 0");
      end
    end
    if (done1) begin
      got_done1++;
      checks++;
      if (prev_done1) begin
        errors++;
        $display("FAIL done1_width got 2 want 1");
      end
    end
    prev_done1 <= done1;
  end

  // monitor for the STEP=2 instance
  always @(negedge clk) begin
    int e;
    if (busy2) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL dat2_extra got %0d want none", b2.dat);
      end else begin
        e = q2.pop_front();
        if (int'(b2.dat) != e) begin
          errors++;
          $display("FAIL dat2 got %0d want %0d", b2.dat, e);
        end
      end
    end
    if (done2) got_done2++;
  end

  task automatic go(input int l, input int i, input int m, input bit two);
    @(negedge clk);
    len  = 16'(l);
    init = 16'(i);
    mode = 2'(m);
    if (two) start2 = 1'b1;
    else start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    start2 = 1'b0;
    repeat (l + 2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 0; start2 = 0; stop = 0;
    len = 0; init = 0; mode = 0;
    repeat (2) @(negedge clk);
    chk("rst_dat", int'(b1.dat), 0);
    chk("rst_busy", int'(busy1), 0);
    chk("rst_done", int'(done1), 0);
    rst = 1'b0;

    for (int v = 0; v < 5; v++) q1.push_back(v);
    exp_done1++;
    go(5, 0, 0, 0);
    chk("hold_after", int'(b1.dat), 4);

    q1.push_back(14); q1.push_back(15);
    q1.push_back(0);  q1.push_back(1);
    exp_done1++;
    go(4, 14, 0, 0);

    q1.push_back(1); q1.push_back(0); q1.push_back(15);
    exp_done1++;
    go(3, 1, 1, 0);

    q2.push_back(13); q2.push_back(15);
    q2.push_back(15); q2.push_back(15);
    exp_done2++;
    go(4, 13, 2, 1);

    for (int v = 13; v < 16; v++) q1.push_back(v);
    for (int v = 14; v > 9; v--) q1.push_back(v);
    exp_done1++;
    go(8, 13, 3, 0);

    for (int v = 1; v < 5; v++) q1.push_back(v);
    exp_done1++;
    go(4, 1, 3, 0);

    q1.push_back(14); q1.push_back(15);
    for (int v = 14; v >= 0; v--) q1.push_back(v);
    q1.push_back(1); q1.push_back(2);
    exp_done1++;
    go(19, 14, 3, 0);

    q1.push_back(15); q1.push_back(15); q1.push_back(14);
    exp_done1++;
    go(3, 15, 3, 0);

    // len=0: done pulses, no values, dat unchanged
    @(negedge clk);
    len = 0; init = 9; mode = 0; start = 1;
    @(negedge clk);
    start = 0;
    chk("len0_done", int'(done1), 1);
    chk("len0_busy", int'(busy1), 0);
    chk("len0_dat", int'(b1.dat), 14);
    exp_done1++;
    @(negedge clk);
    chk("len0_done_end", int'(done1), 0);

    // start and stop together in IDLE
    @(negedge clk);
    len = 5; init = 3; start = 1; stop = 1;
    @(negedge clk);
    start = 0; stop = 0;
    chk("conflict_busy", int'(busy1), 0);
    chk("conflict_dat", int'(b1.dat), 14);

    // abort in the 3rd burst cycle
    @(negedge clk);
    len = 10; init = 2; mode = 0; start = 1;
    q1.push_back(2); q1.push_back(3); q1.push_back(4);
    @(negedge clk);
    start = 0;
    @(negedge clk);
    @(negedge clk);
    stop = 1;
    @(negedge clk);
    stop = 0;
    chk("abort_busy", int'(busy1), 0);
    chk("abort_done", int'(done1), 0);
    chk("abort_dat", int'(b1.dat), 4);
    repeat (2) @(negedge clk);
    chk("abort_hold", int'(b1.dat), 4);

    // start in RUN and in DONE is ignored
    @(negedge clk);
    len = 3; init = 7; mode = 0; start = 1;
    q1.push_back(7); q1.push_back(8); q1.push_back(9);
    exp_done1++;
    @(negedge clk);
    start = 0; len = 9; init = 0;
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    chk("done_state", int'(done1), 1);
    start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    chk("ign_busy", int'(busy1), 0);
    chk("ign_dat", int'(b1.dat), 9);

    // reset mid-burst
    @(negedge clk);
    len = 10; init = 5; mode = 0; start = 1;
    q1.push_back(5); q1.push_back(6);
    @(negedge clk);
    start = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("mrst_dat", int'(b1.dat), 0);
    chk("mrst_busy", int'(busy1), 0);
    repeat (3) @(negedge clk);
    chk("mrst_idle", int'(busy1), 0);

    chk("q1_empty", q1.size(), 0);
    chk("q2_empty", q2.size(), 0);
    chk("done1_cnt", got_done1, exp_done1);
    chk("done2_cnt", got_done2, exp_done2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_counter_gen.md
Name: bus_counter_gen

Overview:
- Upstream source stage for the `bus` interface.
- On a start request it drives a programmable burst of counter values onto `bus.dat`, one value per clock. The downstream buffer stage consumes these values.
- Data width is never a parameter of this block. It is read from the connected interface instance's `DW` parameter.
- Supports wrap, saturate and ping-pong counting, with burst length, start value and abort controlled at run time.

Parameters:
- STEP, 1, increment/decrement per cycle. Legal range 1..2^DW-1. Truncated to DW bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- stop  input  1  abort the running burst; sampled only in RUN, plus the IDLE start/stop conflict below.
- len  input  16  burst length in values, latched at start.
- init  input  16  first value, latched at start; low DW bits used.
- mode  input  2  00 up-wrap, 01 down-wrap, 10 up-saturate, 11 ping-pong; latched at start.
- busy  output  1  high exactly while burst values are on o.dat.
- done  output  1  one-cycle pulse when a burst completes normally.
- o  modport bus.o  DW  drives o.dat; DW = o.DW (localparam derived from the interface).

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, ports named clk and rst.
- Reset (synchronous, wins over all inputs, including mid-burst):
  - state=IDLE, o.dat=0, busy=0, done=0.
  - Remaining counter=0, direction=up.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1, stop=0, len!=0 at edge k:
    - from edge k: state=RUN, o.dat=init[DW-1:0], busy=1;
    - rem=len-1; mode latched; dir=up.
  - start=1, len=0: state=DONE, busy stays 0, o.dat unchanged.
  - start=1 and stop=1 together: stop wins; remain IDLE.
- RUN (checked in this order each edge):
  - stop=1: next state IDLE, busy=0, done=0, o.dat holds current value.
  - else rem==0: next state DONE, busy=0, done=1, o.dat holds last value.
  - else: o.dat=next(o.dat), rem=rem-1.
  - start ignored while in RUN.
- DONE: one cycle; next state IDLE, done=0; start ignored in DONE.
- Burst timing: start at edge k gives values on o.dat after edges k..k+len-1; done is high for the cycle after edge k+len.
- next() per mode (MAX=2^DW-1, sums computed in DW+1 bits):
  - 00: (dat+STEP) mod 2^DW.
  - 01: (dat-STEP) mod 2^DW.
  - 10: min(dat+STEP, MAX); holds at MAX once reached.
  - 11, dir=up: if dat+STEP>=MAX then dat=MAX, dir=down; else dat+STEP.
  - 11, dir=down: if dat<=STEP then dat=0, dir=up; else dat-STEP.
  - 11 with init=MAX: repeats MAX once, then descends.
- o.dat changes only in RUN or at reset; holds in IDLE and DONE.
- busy and done are never high together.
- len is a 16-bit unsigned value; len=65535 must work.

Test Plan:
- DW=4, STEP=1, rst 2 cycles, then start len=5 init=0 mode=00 -> o.dat 0,1,2,3,4 with busy=1 for 5 cycles; done=1 next cycle; o.dat holds 4.
- mode=00 init=14 len=4 -> 14,15,0,1. mode=01 init=1 len=3 -> 1,0,15.
- STEP=2, mode=10 init=13 len=4 -> 13,15,15,15. STEP=1, mode=11 init=13 len=8 -> 13,14,15,14,13,12,11,10. Also mode=11 init=1 len=4 -> 1,2,3,4, and a down-sweep through 0 -> ...,1,0,1,2.
- len=0 start -> busy never rises; done pulses one cycle after start; o.dat unchanged.
- Abort: stop at 3rd burst cycle -> busy low next cycle, done stays 0, o.dat frozen. Separately, rst mid-burst -> o.dat=0, busy=0 next edge.
- start+stop together in IDLE -> no burst. start pulsed during RUN and in DONE -> ignored; original burst length unchanged.
